fdc_sif_slave: RTL and testbench

Drive-side serial interface of the floppy subsystem: the stage directly downstream of the 1801VP1-033 in FDC mode. It consumes the serial command/data stream that the 033 drives on nDO/nRUN and generates the shift clock. It also runs the nDONE/nTR/nERR handshake and holds the sector buffer for the fill, empty and status functions. It is synthesizable and replaces the behavioural drive model on the board-level path.

---
 rtl/fdc_pkg.sv | 36 +++
 rtl/fdc_sbuf.sv | 23 ++
 rtl/fdc_sif_slave.sv | 213 +++++++++++++++++++++
 tb/tb_fdc_sif_slave.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// Shared definitions for the drive-side serial interface.
// Function codes, FSM state encoding and status byte layout.
package fdc_pkg;

    localparam logic [2:0] FN_FILL   = 3'b000;
    localparam logic [2:0] FN_EMPTY  = 3'b001;
    localparam logic [2:0] FN_STATUS = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_DECODE   = 3'd2,
        ST_WAIT_TR  = 3'd3,
        ST_RX       = 3'd4,
        ST_TX       = 3'd5,
        ST_WAIT_ACK = 3'd6
    } fdcState_t;

    localparam int STS_INIT    = 0;
    localparam int STS_ILLEGAL = 1;
    localparam int STS_UNIT    = 7;

    function automatic logic [7:0] makeStatus(
        input logic unit,
        input logic illegal,
        input logic initDone
    );
        logic [7:0] s;
        s              = 8'h00;
        s[STS_UNIT]    = unit;
        s[STS_ILLEGAL] = illegal;
        s[STS_INIT]    = initDone;
        return s;
    endfunction

endpackage

// File: rtl/fdc_sbuf.sv
// Sector buffer: single-port synchronous RAM, registered read.
// Ports: CLK, we, addr, wdata (write), rdata (1-clock read).
module fdc_sbuf #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/fdc_sif_slave.sv
// Drive-side serial slave behind the 1801VP1-033: shift clock,
// nDONE/nTR/nERR handshake, buffer fill/empty and status.
// Ports: CLK, RST (sync, high), PIN_nDO/nRUN/nSET in,
// PIN_nSHIFT/nOUT/nDI/nERR/nDONE/nTR out (all registered).
module fdc_sif_slave
    import fdc_pkg::*;
#(
    parameter int BUF_LEN = 128
) (
    input  logic CLK,
    input  logic RST,
    output logic PIN_nSHIFT,
    output logic PIN_nOUT,
    output logic PIN_nDI,
    input  logic PIN_nDO,
    input  logic PIN_nRUN,
    input  logic PIN_nSET,
    output logic PIN_nERR,
    output logic PIN_nDONE,
    output logic PIN_nTR
);

    localparam int AW = $clog2(BUF_LEN);
    localparam logic [AW-1:0] LAST = AW'(BUF_LEN - 1);

    fdcState_t     state;
    logic          runSync;
    logic          runPrev;
    logic          runFall;
    logic          abort;
    logic          phaseB;
    logic [3:0]    bitCnt;
    logic [7:0]    sr;
    logic [AW-1:0] ptr;
    logic          illegalFn;
    logic          initDone;
    logic          singleByte;
    logic [AW-1:0] ramAddr;
    logic          ramWe;
    logic [7:0]    ramRdata;
    logic [7:0]    statusByte;
    logic          lastBit;

    // nRUN is sampled freely so a level held across abort
    // never produces a false edge afterwards.
    always_ff @(posedge CLK) begin
        runSync <= PIN_nRUN;
        runPrev <= runSync;
    end

    assign runFall = runPrev & ~runSync;
    assign abort   = RST | ~PIN_nSET;
    assign lastBit = phaseB && (bitCnt == 4'd1);

    // Address is steered ahead of use: buf[0] is read during
    // the last command bit, buf[ptr+1] while waiting for ack.
    always_comb begin
        ramAddr = ptr;
        if (state == ST_WAIT_ACK) begin
            ramAddr = ptr + 1'b1;
        end else if (state == ST_CMD) begin
            ramAddr = '0;
        end
    end

    assign ramWe = !abort && (state == ST_RX) && lastBit;

    always_comb begin
        statusByte = makeStatus(sr[4], illegalFn, initDone);
    end

    fdc_sbuf #(
        .DEPTH(BUF_LEN),
        .AW   (AW)
    ) u_sbuf (
        .CLK  (CLK),
        .we   (ramWe),
        .addr (ramAddr),
        .wdata(sr),
        .rdata(ramRdata)
    );

    always_ff @(posedge CLK) begin
        if (abort) begin
            state      <= ST_IDLE;
            PIN_nSHIFT <= 1'b1;
            PIN_nOUT   <= 1'b1;
            PIN_nDI    <= 1'b1;
            PIN_nERR   <= 1'b1;
            PIN_nDONE  <= 1'b1;
            PIN_nTR    <= 1'b1;
            phaseB     <= 1'b0;
            bitCnt     <= 4'd0;
            sr         <= 8'h00;
            ptr        <= '0;
            illegalFn  <= 1'b0;
            initDone   <= 1'b1;
            singleByte <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    PIN_nDONE <= 1'b0;
                    if (runFall) begin
                        PIN_nDONE <= 1'b1;
                        bitCnt    <= 4'd8;
                        phaseB    <= 1'b0;
                        state     <= ST_CMD;
                    end
                end
                ST_CMD, ST_RX, ST_TX: begin
                    if (!phaseB) begin
                        PIN_nSHIFT <= 1'b0;
                        phaseB     <= 1'b1;
                        if (state == ST_TX) begin
                            PIN_nDI <= ~sr[7];
                        end else begin
                            sr <= {sr[6:0], ~PIN_nDO};
                        end
                    end else begin
                        PIN_nSHIFT <= 1'b1;
                        phaseB     <= 1'b0;
                        bitCnt     <= bitCnt - 4'd1;
                        if (state == ST_TX) begin
                            sr <= {sr[6:0], 1'b0};
                        end
                        if (bitCnt == 4'd1) begin
                            if (state == ST_CMD) begin
                                state <= ST_DECODE;
                            end else if (state == ST_RX) begin
                                ptr <= ptr + 1'b1;
                                if (ptr == LAST) begin
                                    PIN_nOUT  <= 1'b1;
                                    PIN_nERR  <= 1'b1;
                                    PIN_nDONE <= 1'b0;
                                    state     <= ST_IDLE;
                                end else begin
                                    PIN_nTR <= 1'b0;
                                    state   <= ST_WAIT_TR;
                                end
                            end else begin
                                PIN_nTR <= 1'b0;
                                state   <= ST_WAIT_ACK;
                            end
                        end
                    end
                end
                ST_DECODE: begin
                    bitCnt <= 4'd8;
                    phaseB <= 1'b0;
                    unique case (sr[3:1])
                        FN_FILL: begin
                            illegalFn <= 1'b0;
                            ptr       <= '0;
                            PIN_nTR   <= 1'b0;
                            state     <= ST_WAIT_TR;
                        end
                        FN_EMPTY: begin
                            illegalFn  <= 1'b0;
                            singleByte <= 1'b0;
                            ptr        <= '0;
                            PIN_nOUT   <= 1'b0;
                            sr         <= ramRdata;
                            state      <= ST_TX;
                        end
                        FN_STATUS: begin
                            // status reports the flag, then clears it
                            illegalFn  <= 1'b0;
                            singleByte <= 1'b1;
                            PIN_nOUT   <= 1'b0;
                            sr         <= statusByte;
                            state      <= ST_TX;
                        end
                        default: begin
                            illegalFn <= 1'b1;
                            PIN_nERR  <= 1'b0;
                            PIN_nDONE <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    endcase
                end
                ST_WAIT_TR: begin
                    if (runFall) begin
                        PIN_nTR <= 1'b1;
                        bitCnt  <= 4'd8;
                        phaseB  <= 1'b0;
                        state   <= ST_RX;
                    end
                end
                ST_WAIT_ACK: begin
                    if (runFall) begin
                        PIN_nTR <= 1'b1;
                        if (singleByte || (ptr == LAST)) begin
                            PIN_nOUT  <= 1'b1;
                            PIN_nERR  <= 1'b1;
                            PIN_nDONE <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            ptr    <= ptr + 1'b1;
                            sr     <= ramRdata;
                            bitCnt <= 4'd8;
                            phaseB <= 1'b0;
                            state  <= ST_TX;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdc_sif_slave.sv
// Directed bench for fdc_sif_slave: host side of the serial
// link driving status, fill, empty, illegal, abort and nRUN hold.
module tb_fdc_sif_slave;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic nDO = 1'b1;
    logic nRUN = 1'b1;
    logic nSET = 1'b1;
    logic nShift, nOut, nDi, nErr, nDone, nTr;
    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fdc_sif_slave #(.BUF_LEN(128)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PIN_nSHIFT(nShift),
        .PIN_nOUT  (nOut),
        .PIN_nDI   (nDi),
        .PIN_nDO   (nDO),
        .PIN_nRUN  (nRUN),
        .PIN_nSET  (nSET),
        .PIN_nERR  (nErr),
        .PIN_nDONE (nDone),
        .PIN_nTR   (nTr)
    );

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // sel: 0 nSHIFT, 1 nTR, 2 nDONE
    task automatic waitFor(input int sel, input logic val,
                           input string tag, output logic ok);
        logic s;
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok) begin
            case (sel)
                0: s = nShift;
                1: s = nTr;
                default: s = nDone;
            endcase
            if (s === val) begin
                ok = 1'b1;
            end else if (n >= 200) begin
                checks++;
                errors++;
                $error("FAIL timeout %s: got %b expected %b", tag, s, val);
                break;
            end else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic runPulse();
        nRUN = 1'b0;
        tick();
        nRUN = 1'b1;
    endtask

    task automatic sendBits(input logic [7:0] b, input int fromBit);
        logic ok;
        for (int k = fromBit; k < 8; k++) begin
            waitFor(0, 1'b0, "txShiftLo", ok);
            waitFor(0, 1'b1, "txShiftHi", ok);
            if (k < 7) nDO = ~b[6-k];
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit hold);
        nDO  = ~b[7];
        nRUN = 1'b0;
        tick();
        if (!hold) nRUN = 1'b1;
        sendBits(b, 0);
    endtask

    task automatic recvBits(output logic [7:0] b, output logic bad);
        logic ok;
        b   = 8'h00;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            waitFor(0, 1'b0, "rxShiftLo", ok);
            b = {b[6:0], ~nDi};
            if (nOut !== 1'b0) bad = 1'b1;
            waitFor(0, 1'b1, "rxShiftHi", ok);
        end
    endtask

    task automatic statusCmd(input logic [7:0] cmd, input logic [7:0] exp,
                             input string tag);
        logic [7:0] b;
        logic bad, ok;
        sendByte(cmd, 1'b0);
        recvBits(b, bad);
        chk(tag, b, exp);
        waitFor(1, 1'b0, "statusTr", ok);
        runPulse();
        waitFor(2, 1'b0, "statusDone", ok);
        chk({tag, "_nErr"}, 8'(nErr), 8'd1);
        chk({tag, "_nOut"}, 8'(nOut), 8'd1);
    endtask

    // mode 1: first five bytes come from the aborted refill
    task automatic emptyAll(input int mode);
        logic [7:0] b, e;
        logic bad, anyBad, ok;
        anyBad = 1'b0;
        sendByte(8'o002, 1'b0);
        for (int i = 0; i < 128; i++) begin
            if (i > 0) begin
                waitFor(1, 1'b0, "emptyTr", ok);
                runPulse();
            end
            recvBits(b, bad);
            anyBad = anyBad | bad;
            e = (mode == 1 && i < 5) ? 8'(8'hC0 + i) : 8'(i);
            chk($sformatf("empty%0d[%0d]", mode, i), b, e);
        end
        waitFor(1, 1'b0, "emptyLastTr", ok);
        runPulse();
        waitFor(2, 1'b0, "emptyDone", ok);
        chk("emptyNoutLow", 8'(anyBad), 8'd0);
        chk("emptyNoutEnd", 8'(nOut), 8'd1);
        chk("emptyNerr", 8'(nErr), 8'd1);
    endtask

    initial begin
        logic ok, bad;
        logic [7:0] v;
        int reqs;

        // reset
        repeat (3) tick();
        chk("rstOuts", {2'b0, nShift, nOut, nDi, nErr, nDone, nTr}, 8'h3F);
        RST = 1'b0;
        tick();
        chk("rstDoneLow", 8'(nDone), 8'd0);
        chk("rstTrHigh", 8'(nTr), 8'd1);
        tick();

        // command latency: run_fall at N, nDONE high N+1, shift N+2
        v = 8'o012;
        nDO = ~v[7];
        nRUN = 1'b0;
        tick();
        nRUN = 1'b1;
        chk("latDoneN", 8'(nDone), 8'd0);
        tick();
        chk("latDoneN1", 8'(nDone), 8'd1);
        chk("latShiftN1", 8'(nShift), 8'd1);
        tick();
        chk("latShiftN2", 8'(nShift), 8'd0);
        sendBits(v, 0);
        recvBits(v, bad);
        chk("statusRst", v, 8'o001);
        waitFor(1, 1'b0, "statusTr", ok);
        runPulse();
        waitFor(2, 1'b0, "statusDone", ok);
        chk("statusRstErr", 8'(nErr), 8'd1);

        // full fill with 0..127
        reqs = 0;
        sendByte(8'o000, 1'b0);
        for (int i = 0; i < 128; i++) begin
            waitFor(1, 1'b0, "fillTr", ok);
            if (ok) reqs++;
            sendByte(8'(i), 1'b0);
        end
        waitFor(2, 1'b0, "fillDone", ok);
        chk("fillReqs", 8'(reqs), 8'd128);
        chk("fillErr", 8'(nErr), 8'd1);
        chk("fillTrEnd", 8'(nTr), 8'd1);
        tick();

        emptyAll(0);
        tick();

        // illegal function, then status twice
        sendByte(8'o010, 1'b0);
        waitFor(2, 1'b0, "illDone", ok);
        chk("illErr", 8'(nErr), 8'd0);
        chk("illDone", 8'(nDone), 8'd0);
        tick();
        statusCmd(8'o012, 8'o003, "statusIll");
        tick();
        statusCmd(8'o032, 8'o201, "statusUnit");
        tick();

        // refill 0..4, abort in the 4th bit of byte 5
        sendByte(8'o000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            waitFor(1, 1'b0, "refillTr", ok);
            sendByte(8'(8'hC0 + i), 1'b0);
        end
        waitFor(1, 1'b0, "refillTr5", ok);
        v = 8'hE7;
        nDO = ~v[7];
        runPulse();
        for (int k = 0; k < 3; k++) begin
            waitFor(0, 1'b0, "abShiftLo", ok);
            waitFor(0, 1'b1, "abShiftHi", ok);
            nDO = ~v[6-k];
        end
        waitFor(0, 1'b0, "abBit4", ok);
        nSET = 1'b0;
        tick();
        chk("abortOuts", {2'b0, nShift, nOut, nDi, nErr, nDone, nTr}, 8'h3F);
        nSET = 1'b1;
        nDO = 1'b1;
        tick();
        chk("abortDone", 8'(nDone), 8'd0);
        tick();
        emptyAll(1);
        tick();

        // nRUN held low across command and byte boundaries
        sendByte(8'o000, 1'b1);
        waitFor(1, 1'b0, "holdTr0", ok);
        bad = 1'b0;
        repeat (24) begin
            tick();
            if (nShift !== 1'b1) bad = 1'b1;
        end
        chk("holdCmdNoShift", 8'(bad), 8'd0);
        chk("holdCmdTr", 8'(nTr), 8'd0);
        nRUN = 1'b1;
        repeat (2) tick();
        sendByte(8'h5A, 1'b1);
        waitFor(1, 1'b0, "holdTr1", ok);
        bad = 1'b0;
        repeat (24) begin
            tick();
            if (nShift !== 1'b1) bad = 1'b1;
        end
        chk("holdByteNoShift", 8'(bad), 8'd0);
        chk("holdByteTr", 8'(nTr), 8'd0);
        nRUN = 1'b1;
        repeat (2) tick();
        sendByte(8'h3C, 1'b0);
        waitFor(1, 1'b0, "holdTr2", ok);
        chk("holdResumeTr", 8'(nTr), 8'd0);
        nSET = 1'b0;
        tick();
        nSET = 1'b1;
        tick();
        chk("endDone", 8'(nDone), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
